csr_birimi: RTL and testbench

- Machine-mode CSR file of the RV32 core: holds status, trap, FP-control and performance-counter registers.
- Provides a combinational read port to the decode stage and a write port from write-back.
- Captures exceptions reported by write-back, then issues a pipeline flush and a redirect to the trap vector.

---
 rtl/csr_birimi_if.sv | 39 +++
 rtl/csr_birimi.sv | 145 ++++++++++++++
 tb/tb_csr_birimi.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_birimi_if.sv
// Bus bundle between the pipeline (decode / write-back / stall sources) and the CSR file.
interface csr_birimi_if #(parameter int XLEN = 32);
  logic [11:0]     adres_i;
  logic [XLEN-1:0] csr_o;
  logic [11:0]     yaz_adres_i;
  logic [XLEN-1:0] veri_i;
  logic            yaz_i;
  logic            buyruk_tamamlandi_i;
  logic [4:0]      fflag_i;
  logic            fflag_yaz_i;
  logic [2:0]      frm_o;
  logic [1:0]      fs_o;
  logic [25:0]     misa_ext_o;
  logic [3:0]      gy_mcause_ic_i;
  logic [XLEN-1:0] gy_mepc_i;
  logic [XLEN-1:0] gy_mtval_i;
  logic            exc_yaz_i;
  logic            bh_bosalt_o;
  logic            bh_ex_atla_o;
  logic [XLEN-1:0] bh_atla_pc_o;
  logic            yurut_stall_i;
  logic            l1v_stall_i;
  logic            l1b_stall_i;
  logic            gs_stall_i;

  modport master (
    output adres_i, yaz_adres_i, veri_i, yaz_i, buyruk_tamamlandi_i, fflag_i, fflag_yaz_i,
           gy_mcause_ic_i, gy_mepc_i, gy_mtval_i, exc_yaz_i,
           yurut_stall_i, l1v_stall_i, l1b_stall_i, gs_stall_i,
    input  csr_o, frm_o, fs_o, misa_ext_o, bh_bosalt_o, bh_ex_atla_o, bh_atla_pc_o
  );

  modport slave (
    input  adres_i, yaz_adres_i, veri_i, yaz_i, buyruk_tamamlandi_i, fflag_i, fflag_yaz_i,
           gy_mcause_ic_i, gy_mepc_i, gy_mtval_i, exc_yaz_i,
           yurut_stall_i, l1v_stall_i, l1b_stall_i, gs_stall_i,
    output csr_o, frm_o, fs_o, misa_ext_o, bh_bosalt_o, bh_ex_atla_o, bh_atla_pc_o
  );
endinterface

// File: rtl/csr_birimi.sv
// Machine-mode CSR file: status/trap/FP-control registers, 64-bit cycle/instret and
// four event counters; exceptions are captured and followed by a one-cycle flush/redirect.
module csr_birimi #(
  parameter int          XLEN     = 32,
  parameter logic [25:0] MISA_EXT = 26'h0001120
) (
  input logic         clk_i,
  input logic         rstn_i,
  csr_birimi_if.slave bus
);
  localparam logic [XLEN-1:0] MISA = {2'b01, 4'b0, MISA_EXT};

  logic            mie, mpie, mie_nxt, mpie_nxt;
  logic [1:0]      fs, fs_nxt;
  logic [4:0]      fflags, fflags_nxt;
  logic [2:0]      frm, frm_nxt;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [XLEN-1:0] mtvec_nxt, mscratch_nxt, mepc_nxt, mcause_nxt, mtval_nxt;
  logic [63:0]     mcycle, minstret, mcycle_nxt, minstret_nxt, mcycle_inc, minstret_inc;
  logic [XLEN-1:0] hpm [4];
  logic [XLEN-1:0] hpm_nxt [4];
  logic [3:0]      hpm_event;
  logic            exc_pend;
  logic [XLEN-1:0] rdata;

  function automatic logic wr_hit(input logic [11:0] a);
    return bus.yaz_i && (bus.yaz_adres_i == a);
  endfunction

  assign hpm_event    = {bus.gs_stall_i, bus.l1b_stall_i, bus.l1v_stall_i, bus.yurut_stall_i};
  assign mcycle_inc   = mcycle + 64'd1;
  assign minstret_inc = minstret + {63'b0, bus.buyruk_tamamlandi_i};

  always_comb begin
    rdata = '0;
    case (bus.adres_i)
      12'h001:          rdata = {27'b0, fflags};
      12'h002:          rdata = {29'b0, frm};
      12'h003:          rdata = {24'b0, frm, fflags};
      12'h300:          rdata = {17'b0, fs, 5'b0, mpie, 3'b0, mie, 3'b0};
      12'h301:          rdata = MISA;
      12'h305:          rdata = mtvec;
      12'h340:          rdata = mscratch;
      12'h341:          rdata = mepc;
      12'h342:          rdata = mcause;
      12'h343:          rdata = mtval;
      12'hB00, 12'hC00: rdata = mcycle[31:0];
      12'hB80, 12'hC80: rdata = mcycle[63:32];
      12'hB02, 12'hC02: rdata = minstret[31:0];
      12'hB82, 12'hC82: rdata = minstret[63:32];
      12'hB03:          rdata = hpm[0];
      12'hB04:          rdata = hpm[1];
      12'hB05:          rdata = hpm[2];
      12'hB06:          rdata = hpm[3];
      default:          rdata = '0;
    endcase
  end

  always_comb begin
    fflags_nxt = (wr_hit(12'h001) || wr_hit(12'h003)) ? bus.veri_i[4:0] : fflags;
    if (bus.fflag_yaz_i) fflags_nxt = fflags_nxt | bus.fflag_i;

    frm_nxt = frm;
    if (wr_hit(12'h002))      frm_nxt = bus.veri_i[2:0];
    else if (wr_hit(12'h003)) frm_nxt = bus.veri_i[7:5];

    // Any FP state change marks the context dirty, even if mstatus is written alongside.
    fs_nxt = fs;
    if (wr_hit(12'h001) || wr_hit(12'h002) || wr_hit(12'h003) || bus.fflag_yaz_i) fs_nxt = 2'd3;
    else if (wr_hit(12'h300)) fs_nxt = bus.veri_i[14:13];

    mie_nxt  = mie;
    mpie_nxt = mpie;
    if (bus.exc_yaz_i) begin
      mie_nxt  = 1'b0;
      mpie_nxt = mie;
    end else if (wr_hit(12'h300)) begin
      mie_nxt  = bus.veri_i[3];
      mpie_nxt = bus.veri_i[7];
    end

    mtvec_nxt    = wr_hit(12'h305) ? (bus.veri_i & ~32'h3) : mtvec;
    mscratch_nxt = wr_hit(12'h340) ? bus.veri_i : mscratch;
    mepc_nxt     = bus.exc_yaz_i ? (bus.gy_mepc_i & ~32'h1) :
                   wr_hit(12'h341) ? (bus.veri_i & ~32'h1) : mepc;
    mcause_nxt   = bus.exc_yaz_i ? {28'b0, bus.gy_mcause_ic_i} :
                   wr_hit(12'h342) ? bus.veri_i : mcause;
    mtval_nxt    = bus.exc_yaz_i ? bus.gy_mtval_i :
                   wr_hit(12'h343) ? bus.veri_i : mtval;

    // A low-half write suppresses the carry into the high half.
    mcycle_nxt[31:0]  = wr_hit(12'hB00) ? bus.veri_i : mcycle_inc[31:0];
    mcycle_nxt[63:32] = wr_hit(12'hB80) ? bus.veri_i :
                        wr_hit(12'hB00) ? mcycle[63:32] : mcycle_inc[63:32];
    minstret_nxt[31:0]  = wr_hit(12'hB02) ? bus.veri_i : minstret_inc[31:0];
    minstret_nxt[63:32] = wr_hit(12'hB82) ? bus.veri_i :
                          wr_hit(12'hB02) ? minstret[63:32] : minstret_inc[63:32];

    for (int i = 0; i < 4; i++) begin
      hpm_nxt[i] = wr_hit(12'hB03 + 12'(i)) ? bus.veri_i : hpm[i] + {31'b0, hpm_event[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      fs       <= 2'd1;
      fflags   <= '0;
      frm      <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mcycle   <= '0;
      minstret <= '0;
      for (int i = 0; i < 4; i++) hpm[i] <= '0;
      exc_pend <= 1'b0;
    end else begin
      mie      <= mie_nxt;
      mpie     <= mpie_nxt;
      fs       <= fs_nxt;
      fflags   <= fflags_nxt;
      frm      <= frm_nxt;
      mtvec    <= mtvec_nxt;
      mscratch <= mscratch_nxt;
      mepc     <= mepc_nxt;
      mcause   <= mcause_nxt;
      mtval    <= mtval_nxt;
      mcycle   <= mcycle_nxt;
      minstret <= minstret_nxt;
      for (int i = 0; i < 4; i++) hpm[i] <= hpm_nxt[i];
      exc_pend <= bus.exc_yaz_i;
    end
  end

  assign bus.csr_o        = rdata;
  assign bus.frm_o        = frm;
  assign bus.fs_o         = fs;
  assign bus.misa_ext_o   = MISA_EXT;
  assign bus.bh_bosalt_o  = exc_pend;
  assign bus.bh_ex_atla_o = exc_pend;
  assign bus.bh_atla_pc_o = exc_pend ? {mtvec[XLEN-1:2], 2'b00} : '0;
endmodule

// File: tb/tb_csr_birimi.sv
// Randomized bench for csr_birimi against a register-level reference model, plus directed scenarios.
module tb_csr_birimi;
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  csr_birimi_if bus ();
  csr_birimi dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic        m_mie, m_mpie, m_pend;
  logic [1:0]  m_fs;
  logic [4:0]  m_fflags;
  logic [2:0]  m_frm;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mcycle, m_minstret;
  logic [31:0] m_hpm [4];

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_pend = 0; m_fs = 2'd1; m_fflags = 0; m_frm = 0;
    m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_mcycle = 0; m_minstret = 0;
    for (int i = 0; i < 4; i++) m_hpm[i] = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [31:0] misa;
    misa = {2'b01, 4'b0, 26'h0001120};
    case (a)
      12'h001: return {27'b0, m_fflags};
      12'h002: return {29'b0, m_frm};
      12'h003: return {24'b0, m_frm, m_fflags};
      12'h300: return (32'(m_fs) << 13) | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return misa;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00, 12'hC00: return m_mcycle[31:0];
      12'hB80, 12'hC80: return m_mcycle[63:32];
      12'hB02, 12'hC02: return m_minstret[31:0];
      12'hB82, 12'hC82: return m_minstret[63:32];
      12'hB03: return m_hpm[0];
      12'hB04: return m_hpm[1];
      12'hB05: return m_hpm[2];
      12'hB06: return m_hpm[3];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_update();
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    logic [63:0] cyc, ins;
    logic [3:0]  ev;
    w = bus.yaz_i; a = bus.yaz_adres_i; d = bus.veri_i;
    ev = {bus.gs_stall_i, bus.l1b_stall_i, bus.l1v_stall_i, bus.yurut_stall_i};

    if (w && a == 12'h301) ; // read-only, nothing to do
    if (w && (a == 12'h001 || a == 12'h003)) m_fflags = d[4:0];
    if (bus.fflag_yaz_i) m_fflags = m_fflags | bus.fflag_i;
    if (w && a == 12'h002) m_frm = d[2:0];
    if (w && a == 12'h003) m_frm = d[7:5];
    if (w && a == 12'h300) m_fs = d[14:13];
    if ((w && a >= 12'h001 && a <= 12'h003) || bus.fflag_yaz_i) m_fs = 2'd3;

    if (bus.exc_yaz_i) begin
      m_mpie = m_mie; m_mie = 0;
    end else if (w && a == 12'h300) begin
      m_mie = d[3]; m_mpie = d[7];
    end
    if (w && a == 12'h305) m_mtvec = d & 32'hFFFF_FFFC;
    if (w && a == 12'h340) m_mscratch = d;
    if (w && a == 12'h341) m_mepc = d & 32'hFFFF_FFFE;
    if (w && a == 12'h342) m_mcause = d;
    if (w && a == 12'h343) m_mtval = d;
    if (bus.exc_yaz_i) begin
      m_mepc = bus.gy_mepc_i & 32'hFFFF_FFFE;
      m_mcause = 32'(bus.gy_mcause_ic_i);
      m_mtval = bus.gy_mtval_i;
    end
    m_pend = bus.exc_yaz_i;

    cyc = m_mcycle + 1;
    if (w && a == 12'hB00) cyc = {m_mcycle[63:32], d};
    if (w && a == 12'hB80) cyc = {d, cyc[31:0]};
    m_mcycle = cyc;
    ins = m_minstret + (bus.buyruk_tamamlandi_i ? 64'd1 : 64'd0);
    if (w && a == 12'hB02) ins = {m_minstret[63:32], d};
    if (w && a == 12'hB82) ins = {d, ins[31:0]};
    m_minstret = ins;
    for (int i = 0; i < 4; i++)
      m_hpm[i] = (w && a == 12'hB03 + 12'(i)) ? d : m_hpm[i] + 32'(ev[i]);
  endtask

  task automatic drive_idle();
    bus.yaz_i = 0; bus.yaz_adres_i = 0; bus.veri_i = 0; bus.buyruk_tamamlandi_i = 0;
    bus.fflag_i = 0; bus.fflag_yaz_i = 0; bus.exc_yaz_i = 0; bus.gy_mcause_ic_i = 0;
    bus.gy_mepc_i = 0; bus.gy_mtval_i = 0; bus.yurut_stall_i = 0; bus.l1v_stall_i = 0;
    bus.l1b_stall_i = 0; bus.gs_stall_i = 0;
  endtask

  // Check all outputs against the model mid-cycle, then advance one clock.
  task automatic tick();
    logic [31:0] pc_exp;
    @(negedge clk_i);
    pc_exp = m_pend ? {m_mtvec[31:2], 2'b00} : 32'h0;
    check($sformatf("rd_%03h", bus.adres_i), bus.csr_o, m_read(bus.adres_i));
    check("frm", 32'(bus.frm_o), 32'(m_frm));
    check("fs", 32'(bus.fs_o), 32'(m_fs));
    check("bosalt", 32'(bus.bh_bosalt_o), 32'(m_pend));
    check("ex_atla", 32'(bus.bh_ex_atla_o), 32'(m_pend));
    check("atla_pc", bus.bh_atla_pc_o, pc_exp);
    check("misa_ext", 32'(bus.misa_ext_o), 32'h0001120);
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.adres_i = a;
    #1;
    check(tag, bus.csr_o, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.yaz_i = 1; bus.yaz_adres_i = a; bus.veri_i = d;
  endtask

  logic [11:0] addrs [30] = '{12'h001, 12'h002, 12'h003, 12'h300, 12'h301, 12'h305, 12'h340,
                              12'h341, 12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                              12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hC00, 12'hC80, 12'hC02,
                              12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h000,
                              12'h344, 12'hC03};

  initial begin
    drive_idle();
    bus.adres_i = 0;
    model_reset();
    @(posedge clk_i); #1;
    rd("rst_mstatus", 12'h300, 32'h0000_2000);
    rd("rst_misa", 12'h301, 32'h4000_1120);
    check("rst_fs", 32'(bus.fs_o), 32'd1);
    check("rst_frm", 32'(bus.frm_o), 32'd0);
    check("rst_bosalt", 32'(bus.bh_bosalt_o), 32'd0);
    check("rst_pc", bus.bh_atla_pc_o, 32'd0);
    @(posedge clk_i); #1;
    rstn_i = 1;

    // Trap entry and redirect
    wr(12'h305, 32'h8000_0103); tick(); drive_idle();
    bus.exc_yaz_i = 1; bus.gy_mepc_i = 32'h100; bus.gy_mcause_ic_i = 4'd2; bus.gy_mtval_i = 32'hDEAD;
    tick(); drive_idle();
    check("trap_bosalt", 32'(bus.bh_bosalt_o), 32'd1);
    check("trap_ex_atla", 32'(bus.bh_ex_atla_o), 32'd1);
    check("trap_pc", bus.bh_atla_pc_o, 32'h8000_0100);
    rd("trap_mepc", 12'h341, 32'h100);
    rd("trap_mcause", 12'h342, 32'd2);
    rd("trap_mtval", 12'h343, 32'hDEAD);
    tick();
    check("trap_drop", 32'(bus.bh_bosalt_o), 32'd0);
    rd("mtvec_mask", 12'h305, 32'h8000_0100);

    // FP control
    wr(12'h003, 32'hE5); tick(); drive_idle();
    check("fcsr_frm", 32'(bus.frm_o), 32'd7);
    check("fcsr_fs", 32'(bus.fs_o), 32'd3);
    rd("fcsr_fflags", 12'h001, 32'h05);
    bus.fflag_yaz_i = 1; bus.fflag_i = 5'h10; tick(); drive_idle();
    rd("fflag_accrue", 12'h001, 32'h15);
    rd("fcsr_read", 12'h003, 32'hF5);

    // Retire counter and cycle wrap
    bus.buyruk_tamamlandi_i = 1;
    repeat (10) tick();
    drive_idle();
    rd("minstret10", 12'hB02, 32'd10);
    rd("instret10", 12'hC02, 32'd10);
    wr(12'hB00, 32'hFFFF_FFFF); tick(); drive_idle();
    rd("mcycleh_pre", 12'hB80, 32'd0);
    tick();
    rd("mcycleh_wrap", 12'hB80, 32'd1);
    rd("cycleh_wrap", 12'hC80, 32'd1);
    rd("mcycle_wrap", 12'hB00, 32'd0);

    // Event counters
    bus.l1b_stall_i = 1;
    repeat (2) tick();
    bus.gs_stall_i = 1; tick(); drive_idle();
    rd("hpm5", 12'hB05, 32'd3);
    rd("hpm6", 12'hB06, 32'd1);
    rd("hpm3", 12'hB03, 32'd0);

    // Exception beats a same-cycle write; unmapped and read-only addresses
    wr(12'h341, 32'h200);
    bus.exc_yaz_i = 1; bus.gy_mepc_i = 32'h300; bus.gy_mcause_ic_i = 4'd5;
    tick(); drive_idle();
    rd("mepc_prio", 12'h341, 32'h300);
    rd("unmapped", 12'h7C0, 32'h0);
    tick();
    wr(12'h301, 32'h0); tick(); drive_idle();
    rd("misa_ro", 12'h301, 32'h4000_1120);

    // Asynchronous reset while a redirect pulse is live
    bus.exc_yaz_i = 1; bus.gy_mepc_i = 32'h44; tick(); drive_idle();
    check("pre_rst_bosalt", 32'(bus.bh_bosalt_o), 32'd1);
    rstn_i = 0;
    #1;
    check("async_rst_bosalt", 32'(bus.bh_bosalt_o), 32'd0);
    check("async_rst_pc", bus.bh_atla_pc_o, 32'd0);
    model_reset();
    rd("async_rst_mepc", 12'h341, 32'd0);
    @(posedge clk_i); #1;
    rstn_i = 1;

    // Randomized traffic against the model
    repeat (3000) begin
      bus.adres_i = addrs[$urandom_range(0, 29)];
      bus.yaz_i = ($urandom_range(0, 2) == 0);
      bus.yaz_adres_i = addrs[$urandom_range(0, 29)];
      bus.veri_i = $urandom;
      bus.buyruk_tamamlandi_i = 1'($urandom);
      bus.fflag_i = 5'($urandom);
      bus.fflag_yaz_i = ($urandom_range(0, 3) == 0);
      bus.exc_yaz_i = ($urandom_range(0, 7) == 0);
      bus.gy_mcause_ic_i = 4'($urandom);
      bus.gy_mepc_i = $urandom;
      bus.gy_mtval_i = $urandom;
      bus.yurut_stall_i = 1'($urandom);
      bus.l1v_stall_i = 1'($urandom);
      bus.l1b_stall_i = 1'($urandom);
      bus.gs_stall_i = 1'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
